// File: rtl/branch_history_table_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table_if
// Description : Fetch/execute side bundle for the branch history table.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_history_table_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  lookupValid;
  logic [ADDR_WIDTH-1:0] lookupPc;
  logic                  predictValid;
  logic                  predictHit;
  logic                  predictTaken;
  logic                  updateValid;
  logic [ADDR_WIDTH-1:0] updatePc;
  logic                  branchTaken;
  logic                  flush;
  logic                  busy;

  modport master (
    output lookupValid, lookupPc, updateValid, updatePc, branchTaken, flush,
    input  predictValid, predictHit, predictTaken, busy
  );

  modport slave (
    input  lookupValid, lookupPc, updateValid, updatePc, branchTaken, flush,
    output predictValid, predictHit, predictTaken, busy
  );
endinterface
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table
// Description : Tagged direct-mapped branch predictor with saturating counters
//               and a sequenced whole-table flush.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table #(
  parameter int ENTRIES       = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 2,
  parameter int INDEX_LSB     = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  branch_history_table_if.slave bus
);
  localparam int c_iw = $clog2(ENTRIES);
  localparam int c_tw = ADDR_WIDTH - INDEX_LSB - c_iw;
  localparam logic [COUNTER_WIDTH-1:0] c_mid   = COUNTER_WIDTH'(2 ** (COUNTER_WIDTH - 1));
  localparam logic [COUNTER_WIDTH-1:0] c_midm1 = COUNTER_WIDTH'(2 ** (COUNTER_WIDTH - 1) - 1);
  localparam logic [COUNTER_WIDTH-1:0] c_max   = '1;
  localparam logic [c_iw-1:0]          c_last  = c_iw'(ENTRIES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_busy;
  logic [c_iw-1:0]          r_fidx;

  logic [ENTRIES-1:0]       r_valid;
  logic [c_tw-1:0]          r_tag [ENTRIES];
  logic [COUNTER_WIDTH-1:0] r_cnt [ENTRIES];

  logic                     r_pv;
  logic                     r_hit;
  logic                     r_taken;

  logic [c_iw-1:0]          w_lk_idx;
  logic [c_tw-1:0]          w_lk_tag;
  logic                     w_lk_hit;
  logic [c_iw-1:0]          w_up_idx;
  logic [c_tw-1:0]          w_up_tag;
  logic                     w_up_hit;
  logic                     w_up_en;

  assign w_lk_idx = bus.lookupPc[INDEX_LSB +: c_iw];
  assign w_lk_tag = bus.lookupPc[ADDR_WIDTH-1 -: c_tw];
  assign w_up_idx = bus.updatePc[INDEX_LSB +: c_iw];
  assign w_up_tag = bus.updatePc[ADDR_WIDTH-1 -: c_tw];

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  // A flush request wins over an update issued in the same idle cycle.
  assign w_up_en  = bus.updateValid && (r_state == S_IDLE) && !bus.flush;

  generate
    if (INDEX_LSB > 0) begin : g_lsb
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^{bus.lookupPc[INDEX_LSB-1:0], bus.updatePc[INDEX_LSB-1:0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.flush) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_busy = 1'b1;
        if (r_fidx == c_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fidx <= '0;
    end else if (r_state == S_FLUSH) begin
      r_fidx <= r_fidx + 1'b1;
    end else begin
      r_fidx <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (r_state == S_FLUSH) begin
      r_valid[r_fidx] <= 1'b0;
    end else if (w_up_en && !w_up_hit) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Tag and counter payload are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_up_en) begin
      if (w_up_hit) begin
        if (bus.branchTaken && (r_cnt[w_up_idx] != c_max)) begin
          r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 1'b1;
        end else if (!bus.branchTaken && (r_cnt[w_up_idx] != '0)) begin
          r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 1'b1;
        end
      end else begin
        r_tag[w_up_idx] <= w_up_tag;
        r_cnt[w_up_idx] <= bus.branchTaken ? c_mid : c_midm1;
      end
    end
  end

  // Reads use pre-edge contents, giving read-before-write on index collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv    <= 1'b0;
      r_hit   <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      r_pv    <= bus.lookupValid;
      r_hit   <= bus.lookupValid && (r_state == S_IDLE) && w_lk_hit;
      r_taken <= bus.lookupValid && (r_state == S_IDLE) && w_lk_hit
                 && (r_cnt[w_lk_idx] >= c_mid);
    end
  end

  assign bus.predictValid = r_pv;
  assign bus.predictHit   = r_hit;
  assign bus.predictTaken = r_taken;
  assign bus.busy         = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_history_table
// Description : Directed vector-table bench for branch_history_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_history_table;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  branch_history_table_if #(.ADDR_WIDTH(32)) bus ();

  branch_history_table #(
    .ENTRIES(64), .ADDR_WIDTH(32), .COUNTER_WIDTH(2), .INDEX_LSB(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        tk;
    logic [2:0]  exp;  // {predictValid, predictHit, predictTaken}
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic lv, input logic [31:0] lpc, input logic uv,
                     input logic [31:0] upc, input logic tk, input logic [2:0] exp);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.tk = tk; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic tk, input logic fl);
    @(negedge clk);
    bus.lookupValid = lv;  bus.lookupPc = lpc;
    bus.updateValid = uv;  bus.updatePc = upc;
    bus.branchTaken = tk;  bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  function automatic logic [2:0] pred();
    return {bus.predictValid, bus.predictHit, bus.predictTaken};
  endfunction

  // Runs a flush from the request cycle; returns how many samples showed busy.
  task automatic run_flush(output int n, input bit mid_traffic);
    step(0, 0, 0, 0, 0, 1);
    check("flush_busy_rise", 32'(bus.busy), 1);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (mid_traffic && n == 1) begin
        step(1, 32'h114, 0, 0, 0, 0);
        check("flush_lookup_miss", 32'(pred()), 3'b100);
      end else if (mid_traffic && n == 10) begin
        step(0, 0, 1, 32'h108, 1, 0);
      end else if (mid_traffic && n == 20) begin
        step(0, 0, 0, 0, 0, 1);
      end else begin
        step(0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  int nbusy;

  initial begin
    errors = 0; checks = 0;
    bus.lookupValid = 0; bus.lookupPc = 0; bus.updateValid = 0;
    bus.updatePc = 0; bus.branchTaken = 0; bus.flush = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pred", 32'(pred()), 3'b000);
    check("reset_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss
    add(1, 32'h100, 0, 0,      0, 3'b100);
    // saturation on 0x100 (index 0)
    add(0, 0,       1, 32'h100, 1, 3'b000);  // alloc -> 2
    add(1, 32'h100, 0, 0,      0, 3'b111);
    add(0, 0,       1, 32'h100, 1, 3'b000);  // 3
    add(0, 0,       1, 32'h100, 1, 3'b000);  // stays 3
    add(0, 0,       1, 32'h100, 0, 3'b000);  // 2
    add(1, 32'h100, 0, 0,      0, 3'b111);
    add(0, 0,       1, 32'h100, 0, 3'b000);  // 1
    add(1, 32'h100, 0, 0,      0, 3'b110);
    add(0, 0,       1, 32'h100, 0, 3'b000);  // 0
    add(0, 0,       1, 32'h100, 0, 3'b000);  // stays 0
    add(0, 0,       1, 32'h100, 1, 3'b000);  // 1
    add(1, 32'h100, 0, 0,      0, 3'b110);
    // alias replacement: retrain then 0x200 overwrites index 0
    add(0, 0,       1, 32'h100, 1, 3'b000);  // 2
    add(0, 0,       1, 32'h100, 1, 3'b000);  // 3
    add(0, 0,       1, 32'h200, 0, 3'b000);  // alloc tag 2, counter 1
    add(1, 32'h100, 0, 0,      0, 3'b100);
    add(1, 32'h200, 0, 0,      0, 3'b110);
    // same-cycle lookup/update to invalid index 1
    add(1, 32'h104, 1, 32'h104, 1, 3'b100);
    add(1, 32'h104, 0, 0,      0, 3'b111);

    foreach (vq[i]) begin
      step(vq[i].lv, vq[i].lpc, vq[i].uv, vq[i].upc, vq[i].tk, 0);
      check($sformatf("vec%0d", i), 32'(pred()), 32'(vq[i].exp));
    end

    // flush: train indices 0, 5, 63
    step(0, 0, 1, 32'h100, 1, 0);
    step(0, 0, 1, 32'h114, 1, 0);
    step(0, 0, 1, 32'h1FC, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0); check("pre_flush_0",  32'(pred()), 3'b111);
    step(1, 32'h114, 0, 0, 0, 0); check("pre_flush_5",  32'(pred()), 3'b111);
    step(1, 32'h1FC, 0, 0, 0, 0); check("pre_flush_63", 32'(pred()), 3'b111);
    run_flush(nbusy, 1'b1);
    check("flush_busy_cycles", 32'(nbusy), 64);
    step(1, 32'h100, 0, 0, 0, 0); check("post_flush_0",   32'(pred()), 3'b100);
    step(1, 32'h114, 0, 0, 0, 0); check("post_flush_5",   32'(pred()), 3'b100);
    step(1, 32'h1FC, 0, 0, 0, 0); check("post_flush_63",  32'(pred()), 3'b100);
    step(1, 32'h108, 0, 0, 0, 0); check("dropped_update", 32'(pred()), 3'b100);

    // reset mid-flush
    step(0, 0, 1, 32'h100, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0); check("pre_rst_hit", 32'(pred()), 3'b111);
    step(0, 0, 0, 0, 0, 1);
    repeat (9) step(0, 0, 0, 0, 0, 0);
    check("busy_before_rst", 32'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 32'h100, 0, 0, 0, 0); check("post_rst_miss", 32'(pred()), 3'b100);
    run_flush(nbusy, 1'b0);
    check("reflush_busy_cycles", 32'(nbusy), 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
